// File: rtl/game_flow_sequencer.sv
// game_flow_sequencer: TITLE/PLAY/OVER screen FSM with acked key events, frame tick,
// three scrolling pipes with random gap heights and a saturating pipes-passed score.
module game_flow_sequencer #(
    parameter int unsigned FRAME_DIV    = 833333,
    parameter int unsigned SCROLL_STEP  = 2,
    parameter int unsigned PIPE_SPACING = 160,
    parameter int unsigned PIPE_START_X = 160,
    parameter int unsigned PIPE_Y_MIN   = 60
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [1:0]  iKeyState,
    output logic        oKeyAck,
    input  logic        iCollide,
    input  logic [31:0] iRandom,
    output logic        oRandomReset,
    output logic [1:0]  oScreen,
    output logic        oWScreen,
    output logic        oBGScroll,
    output logic        oFrameTick,
    output logic        oFlap,
    output logic [9:0]  oPipe1X,
    output logic [9:0]  oPipe2X,
    output logic [9:0]  oPipe3X,
    output logic [8:0]  oPipe1Y,
    output logic [8:0]  oPipe2Y,
    output logic [8:0]  oPipe3Y,
    output logic        oWPipe,
    output logic [15:0] oScore,
    output logic        oWScore
);
    localparam int unsigned     CNT_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
    localparam int unsigned     WRAP_ADD = 3 * PIPE_SPACING - SCROLL_STEP;

    typedef enum logic [1:0] {
        S_TITLE = 2'd0,
        S_PLAY  = 2'd1,
        S_OVER  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] frame_cnt;
    logic [9:0]       pipe_x [3];
    logic [8:0]       pipe_y [3];
    logic             consumed;
    logic [1:0]       consumed_key;

    logic             key_accept;
    logic             key_press;
    logic [9:0]       next_x [3];
    logic [8:0]       next_y [3];
    logic [1:0]       wraps;
    logic [16:0]      score_sum;
    logic [15:0]      next_score;

    function automatic logic [9:0] start_x(input int unsigned k);
        return 10'(PIPE_START_X + k * PIPE_SPACING);
    endfunction

    function automatic logic [8:0] start_y(input int unsigned k);
        return 9'(100 * (k + 1));
    endfunction

    // A level that stays on the same value after being acked is one event, not a stream.
    always_comb begin
        key_accept = (iKeyState != 2'd0) && !oKeyAck &&
                     !(consumed && (iKeyState == consumed_key));
        key_press  = key_accept && (iKeyState == 2'd1);
        wraps      = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            if (pipe_x[k] < 10'(SCROLL_STEP)) begin
                next_x[k] = pipe_x[k] + 10'(WRAP_ADD);
                next_y[k] = 9'(PIPE_Y_MIN) + 9'(iRandom[8*k +: 8]);
                wraps     = wraps + 2'd1;
            end else begin
                next_x[k] = pipe_x[k] - 10'(SCROLL_STEP);
                next_y[k] = pipe_y[k];
            end
        end
        score_sum  = {1'b0, oScore} + 17'(wraps);
        next_score = score_sum[16] ? '1 : score_sum[15:0];
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state        <= S_TITLE;
            frame_cnt    <= '0;
            oFrameTick   <= 1'b0;
            oKeyAck      <= 1'b0;
            oRandomReset <= 1'b0;
            oWScreen     <= 1'b0;
            oFlap        <= 1'b0;
            oWPipe       <= 1'b0;
            oWScore      <= 1'b0;
            oScore       <= '0;
            consumed     <= 1'b0;
            consumed_key <= '0;
            for (int unsigned k = 0; k < 3; k++) begin
                pipe_x[k] <= start_x(k);
                pipe_y[k] <= start_y(k);
            end
        end else begin
            oKeyAck      <= 1'b0;
            oRandomReset <= 1'b0;
            oWScreen     <= 1'b0;
            oFlap        <= 1'b0;
            oWPipe       <= 1'b0;
            oWScore      <= 1'b0;

            frame_cnt  <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + 1'b1;
            oFrameTick <= (frame_cnt == CNT_LAST);

            if (consumed && (iKeyState != consumed_key))
                consumed <= 1'b0;
            if (key_accept) begin
                oKeyAck      <= 1'b1;
                consumed     <= 1'b1;
                consumed_key <= iKeyState;
            end

            case (state)
                S_TITLE: begin
                    if (key_press) begin
                        state        <= S_PLAY;
                        oWScreen     <= 1'b1;
                        oRandomReset <= 1'b1;
                        oWPipe       <= 1'b1;
                        oWScore      <= 1'b1;
                        oScore       <= '0;
                        for (int unsigned k = 0; k < 3; k++) begin
                            pipe_x[k] <= start_x(k);
                            pipe_y[k] <= start_y(k);
                        end
                    end
                end
                S_PLAY: begin
                    if (oFrameTick && iCollide) begin
                        state    <= S_OVER;
                        oWScreen <= 1'b1;
                    end else begin
                        if (oFrameTick) begin
                            pipe_x  <= next_x;
                            pipe_y  <= next_y;
                            oWPipe  <= 1'b1;
                            oScore  <= next_score;
                            oWScore <= (next_score != oScore);
                        end
                        oFlap <= key_press;
                    end
                end
                S_OVER: begin
                    if (key_press) begin
                        state    <= S_TITLE;
                        oWScreen <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_TITLE;
                    oWScreen <= 1'b1;
                end
            endcase
        end
    end

    assign oScreen   = state;
    assign oBGScroll = (state == S_PLAY);
    assign oPipe1X   = pipe_x[0];
    assign oPipe2X   = pipe_x[1];
    assign oPipe3X   = pipe_x[2];
    assign oPipe1Y   = pipe_y[0];
    assign oPipe2Y   = pipe_y[1];
    assign oPipe3Y   = pipe_y[2];

endmodule

// File: tb/tb_game_flow_sequencer.sv
// Bench for game_flow_sequencer: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the game rules.
module tb_game_flow_sequencer;
    localparam int FD = 8;

    logic        iClock = 1'b0;
    logic        iReset;
    logic [1:0]  iKeyState;
    logic        oKeyAck;
    logic        iCollide;
    logic [31:0] iRandom;
    logic        oRandomReset;
    logic [1:0]  oScreen;
    logic        oWScreen, oBGScroll, oFrameTick, oFlap;
    logic [9:0]  oPipe1X, oPipe2X, oPipe3X;
    logic [8:0]  oPipe1Y, oPipe2Y, oPipe3Y;
    logic        oWPipe;
    logic [15:0] oScore;
    logic        oWScore;

    always #5 iClock = ~iClock;

    game_flow_sequencer #(.FRAME_DIV(FD)) dut (
        .iClock(iClock), .iReset(iReset), .iKeyState(iKeyState), .oKeyAck(oKeyAck),
        .iCollide(iCollide), .iRandom(iRandom), .oRandomReset(oRandomReset),
        .oScreen(oScreen), .oWScreen(oWScreen), .oBGScroll(oBGScroll),
        .oFrameTick(oFrameTick), .oFlap(oFlap),
        .oPipe1X(oPipe1X), .oPipe2X(oPipe2X), .oPipe3X(oPipe3X),
        .oPipe1Y(oPipe1Y), .oPipe2Y(oPipe2Y), .oPipe3Y(oPipe3Y),
        .oWPipe(oWPipe), .oScore(oScore), .oWScore(oWScore)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model: screen 0/1/2, cycles since reset, pipe positions as plain ints.
    int m_screen, m_cyc, m_score, m_last_key, m_wraps, m_old;
    int m_x [3];
    int m_y [3];
    bit m_tick, m_ack, m_flap, m_rrst, m_wscreen, m_wpipe, m_wscore;
    bit m_valid = 0;
    bit m_accept, m_press, m_prev_tick;

    always @(posedge iClock) begin
        if (iReset) begin
            m_valid = 1; m_screen = 0; m_cyc = 0; m_score = 0; m_last_key = -1;
            m_tick = 0; m_ack = 0; m_flap = 0; m_rrst = 0;
            m_wscreen = 0; m_wpipe = 0; m_wscore = 0;
            for (int k = 0; k < 3; k++) begin
                m_x[k] = 160 + 160 * k;
                m_y[k] = 100 * (k + 1);
            end
        end else if (m_valid) begin
            m_prev_tick = m_tick;
            m_accept = (iKeyState != 0) && !m_ack && (int'(iKeyState) != m_last_key);
            m_press  = m_accept && (iKeyState == 1);
            if (m_accept) m_last_key = int'(iKeyState);
            else if (int'(iKeyState) != m_last_key) m_last_key = -1;
            m_ack = m_accept;
            m_flap = 0; m_rrst = 0; m_wscreen = 0; m_wpipe = 0; m_wscore = 0;
            m_cyc++;
            m_tick = (m_cyc % FD == 0);
            case (m_screen)
                0: if (m_press) begin
                    m_screen = 1; m_rrst = 1; m_wscreen = 1; m_wpipe = 1; m_wscore = 1;
                    m_score = 0;
                    for (int k = 0; k < 3; k++) begin
                        m_x[k] = 160 + 160 * k;
                        m_y[k] = 100 * (k + 1);
                    end
                end
                1: if (m_prev_tick && iCollide) begin
                    m_screen = 2; m_wscreen = 1;
                end else begin
                    if (m_prev_tick) begin
                        m_wraps = 0;
                        for (int k = 0; k < 3; k++) begin
                            if (m_x[k] >= 2) m_x[k] = m_x[k] - 2;
                            else begin
                                m_x[k] = m_x[k] - 2 + 480;
                                m_y[k] = 60 + int'((iRandom >> (8 * k)) & 32'hFF);
                                m_wraps++;
                            end
                        end
                        m_old = m_score;
                        m_score = (m_score + m_wraps > 65535) ? 65535 : m_score + m_wraps;
                        m_wpipe = 1;
                        m_wscore = (m_score != m_old);
                    end
                    m_flap = m_press;
                end
                default: if (m_press) begin
                    m_screen = 0; m_wscreen = 1;
                end
            endcase
        end
    end

    int ack_seen, tick_seen, wpipe_seen, wscore_seen, rrst_seen, wscreen_seen, flap_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        if (m_valid) begin
            chk("screen", 32'(oScreen), 32'(m_screen));
            chk("wscreen", 32'(oWScreen), 32'(m_wscreen));
            chk("bgscroll", 32'(oBGScroll), 32'(m_screen == 1));
            chk("frametick", 32'(oFrameTick), 32'(m_tick));
            chk("keyack", 32'(oKeyAck), 32'(m_ack));
            chk("randreset", 32'(oRandomReset), 32'(m_rrst));
            chk("flap", 32'(oFlap), 32'(m_flap));
            chk("pipe1x", 32'(oPipe1X), 32'(m_x[0]));
            chk("pipe2x", 32'(oPipe2X), 32'(m_x[1]));
            chk("pipe3x", 32'(oPipe3X), 32'(m_x[2]));
            chk("pipe1y", 32'(oPipe1Y), 32'(m_y[0]));
            chk("pipe2y", 32'(oPipe2Y), 32'(m_y[1]));
            chk("pipe3y", 32'(oPipe3Y), 32'(m_y[2]));
            chk("wpipe", 32'(oWPipe), 32'(m_wpipe));
            chk("score", 32'(oScore), 32'(m_score));
            chk("wscore", 32'(oWScore), 32'(m_wscore));
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge iClock);
            @(negedge iClock);
            check_all();
            ack_seen += int'(oKeyAck);      tick_seen += int'(oFrameTick);
            wpipe_seen += int'(oWPipe);     wscore_seen += int'(oWScore);
            rrst_seen += int'(oRandomReset); wscreen_seen += int'(oWScreen);
            flap_seen += int'(oFlap);
        end
    endtask

    task automatic clear_counts();
        ack_seen = 0; tick_seen = 0; wpipe_seen = 0; wscore_seen = 0;
        rrst_seen = 0; wscreen_seen = 0; flap_seen = 0;
    endtask

    logic [9:0] snap_x1, snap_x2, snap_x3;
    int n;

    initial begin
        iReset = 1; iKeyState = 0; iCollide = 0; iRandom = 0;
        clear_counts();
        step(2);
        chk("rst_screen", 32'(oScreen), 0);
        chk("rst_pipe1x", 32'(oPipe1X), 160);
        chk("rst_pipe3x", 32'(oPipe3X), 480);
        chk("rst_pipe2y", 32'(oPipe2Y), 200);
        chk("rst_score", 32'(oScore), 0);
        iReset = 0;

        // 1: held press gives one event and enters PLAY
        clear_counts();
        iKeyState = 1;
        step(6);
        iKeyState = 0;
        chk("t1_acks", 32'(ack_seen), 1);
        chk("t1_rrst", 32'(rrst_seen), 1);
        chk("t1_wscreen", 32'(wscreen_seen), 1);
        chk("t1_screen", 32'(oScreen), 1);
        chk("t1_pipe1x", 32'(oPipe1X), 160);
        chk("t1_pipe2x", 32'(oPipe2X), 320);
        chk("t1_pipe3x", 32'(oPipe3X), 480);

        // 2: ten ticks of scrolling
        clear_counts();
        for (int i = 0; i < 200 && tick_seen < 10; i++) step(1);
        step(1);
        chk("t2_ticks", 32'(tick_seen), 10);
        chk("t2_pipe1x", 32'(oPipe1X), 140);
        chk("t2_wpipe", 32'(wpipe_seen), 10);
        chk("t2_score", 32'(oScore), 0);
        chk("t2_bgscroll", 32'(oBGScroll), 1);

        // 3: pipe 1 wraps with a known random word
        iRandom = 32'h0000_0010;
        clear_counts();
        for (int i = 0; i < 1000 && wscore_seen == 0; i++) step(1);
        chk("t3_wscore", 32'(wscore_seen), 1);
        chk("t3_pipe1x", 32'(oPipe1X), 478);
        chk("t3_pipe1y", 32'(oPipe1Y), 76);
        chk("t3_score", 32'(oScore), 1);

        // 4: collision tick coinciding with a press
        for (int i = 0; i < 20 && !oFrameTick; i++) step(1);
        chk("t4_tick_found", 32'(oFrameTick), 1);
        snap_x1 = oPipe1X; snap_x2 = oPipe2X; snap_x3 = oPipe3X;
        iCollide = 1; iKeyState = 1;
        clear_counts();
        step(1);
        chk("t4_screen", 32'(oScreen), 2);
        chk("t4_flap", 32'(oFlap), 0);
        chk("t4_ack", 32'(oKeyAck), 1);
        iCollide = 0;
        step(3);
        iKeyState = 0;
        step(1);
        chk("t4_acks", 32'(ack_seen), 1);
        chk("t4_flaps", 32'(flap_seen), 0);
        chk("t4_pipe1x", 32'(oPipe1X), 32'(snap_x1));
        chk("t4_pipe2x", 32'(oPipe2X), 32'(snap_x2));
        chk("t4_pipe3x", 32'(oPipe3X), 32'(snap_x3));

        // 5: OVER -> TITLE keeps score, TITLE -> PLAY reloads
        iKeyState = 1; step(2); iKeyState = 0; step(1);
        chk("t5_title", 32'(oScreen), 0);
        chk("t5_held_score", 32'(oScore), 1);
        iKeyState = 1; step(2); iKeyState = 0; step(1);
        chk("t5_play", 32'(oScreen), 1);
        chk("t5_score", 32'(oScore), 0);
        chk("t5_pipe1x", 32'(oPipe1X), 160);
        chk("t5_pipe1y", 32'(oPipe1Y), 100);
        chk("t5_pipe3y", 32'(oPipe3Y), 300);

        // 6: reset mid-frame restarts the frame counter
        step(3);
        iReset = 1; step(1); iReset = 0;
        chk("t6_screen", 32'(oScreen), 0);
        chk("t6_bgscroll", 32'(oBGScroll), 0);
        chk("t6_tick", 32'(oFrameTick), 0);
        chk("t6_pipe2x", 32'(oPipe2X), 320);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            n++;
            if (oFrameTick) break;
        end
        chk("t6_tick_delay", 32'(n), 8);

        // random play against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) iKeyState = 2'($urandom_range(0, 2));
            iCollide = ($urandom_range(0, 255) == 0);
            iRandom  = $urandom;
            iReset   = ($urandom_range(0, 1499) == 0);
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
